// File: rtl/karplus_pkg.sv
// -----------------------------------------------------------------------------
// karplus_pkg
// Shared definitions for the Karplus-Strong voice:
//   - FSM state encoding (IDLE, LOAD, RUN_WAIT, RUN_RD, RUN_WR)
//   - Galois LFSR tap mask and its single-step helper
//   - minimum sample period in clk cycles that the read/write pipeline supports
// -----------------------------------------------------------------------------
package karplus_pkg;

  localparam logic [2:0] ST_IDLE     = 3'd0;
  localparam logic [2:0] ST_LOAD     = 3'd1;
  localparam logic [2:0] ST_RUN_WAIT = 3'd2;
  localparam logic [2:0] ST_RUN_RD   = 3'd3;
  localparam logic [2:0] ST_RUN_WR   = 3'd4;

  localparam logic [31:0] LFSR_TAPS = 32'h8020_0003;

  // One tick must cover wait, read and write cycles.
  localparam logic [31:0] DIV_MIN = 32'd3;

  // Right-shifting Galois LFSR: the bit shifted out selects the tap mask.
  function automatic logic [31:0] lfsr_step(input logic [31:0] s);
    return (s >> 1) ^ (s[0] ? LFSR_TAPS : 32'd0);
  endfunction

endpackage

// File: rtl/karplus_strong_voice_if.sv
// -----------------------------------------------------------------------------
// karplus_strong_voice_if
// Control/sample bundle between the control-register block (master) and the
// voice (slave).
//   master -> slave : pluck, mute, length, div_in, decay
//   slave -> master : sample_out (signed), sample_valid, busy
// -----------------------------------------------------------------------------
interface karplus_strong_voice_if #(
  parameter int DATA_W  = 16,
  parameter int LEN_W   = 10,
  parameter int DECAY_W = 8
);
  logic                     pluck;
  logic                     mute;
  logic [LEN_W-1:0]         length;
  logic [31:0]              div_in;
  logic [DECAY_W-1:0]       decay;
  logic signed [DATA_W-1:0] sample_out;
  logic                     sample_valid;
  logic                     busy;

  modport master (
    output pluck, mute, length, div_in, decay,
    input  sample_out, sample_valid, busy
  );

  modport slave (
    input  pluck, mute, length, div_in, decay,
    output sample_out, sample_valid, busy
  );
endinterface

// File: rtl/ks_delay_ram.sv
// -----------------------------------------------------------------------------
// ks_delay_ram
// Simple dual-port DEPTH x DATA_W delay-line memory, one write port and one
// synchronous read port, written to map onto a block RAM.
//   clk     : clock
//   we_i    : write enable
//   waddr_i : write address
//   wdata_i : write data
//   raddr_i : read address (data appears on rdata_o after one clk)
//   rdata_o : registered read data
// -----------------------------------------------------------------------------
module ks_delay_ram #(
  parameter int DATA_W = 16,
  parameter int DEPTH  = 1024,
  parameter int AW     = 10
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [AW-1:0]     waddr_i,
  input  logic [DATA_W-1:0] wdata_i,
  input  logic [AW-1:0]     raddr_i,
  output logic [DATA_W-1:0] rdata_o
);
  logic [DATA_W-1:0] mem [DEPTH];
  logic [DATA_W-1:0] rdata_q;

  // NOTE: neither the array nor the read register is reset; a reset port would
  // stop the tools from mapping this onto a block RAM, and LOAD always fills
  // every word before RUN reads it.
  // NOTE: non-blocking assignments keep every register update on this edge
  // order-independent, so a read of a word being written returns old data.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem[waddr_i] <= wdata_i;
    end
    rdata_q <= mem[raddr_i];
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/karplus_strong_voice.sv
// -----------------------------------------------------------------------------
// karplus_strong_voice
// Karplus-Strong plucked-string voice. A pluck fills L words of the delay line
// with LFSR noise, then every div_in clocks the oldest word y is read, averaged
// with the previous y (z), scaled by decay/2^DECAY_W and written back, and the
// result is presented as a signed sample with a one-cycle valid strobe.
//   clk, rst          : clock, asynchronous active-high reset
//   bus.pluck         : start excitation (ignored while loading)
//   bus.mute          : force IDLE, zero output (priority over pluck)
//   bus.length        : delay-line length, latched on pluck, clamped 2..DEPTH
//   bus.div_in        : sample period in clk cycles, values below 3 act as 3
//   bus.decay         : feedback gain numerator
//   bus.sample_out    : signed sample, held between strobes
//   bus.sample_valid  : one-cycle strobe on each new sample
//   bus.busy          : high while loading or running
// -----------------------------------------------------------------------------
module karplus_strong_voice
  import karplus_pkg::*;
#(
  parameter int          DATA_W  = 16,
  parameter int          DEPTH   = 1024,
  parameter int          LEN_W   = 10,
  parameter int          DECAY_W = 8,
  parameter logic [31:0] SEED    = 32'hACE1_0001
) (
  input logic                   clk,
  input logic                   rst,
  karplus_strong_voice_if.slave bus
);
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int PW = DATA_W + DECAY_W + 2;

  logic [2:0]               state_q, state_d;
  logic [AW-1:0]            wp_q, wp_d;
  logic [AW-1:0]            last_q, last_d;   // latched L-1
  logic [31:0]              cnt_q, cnt_d;
  logic [31:0]              lfsr_q, lfsr_d;
  logic signed [DATA_W-1:0] z_q, z_d;
  logic signed [DATA_W-1:0] out_q, out_d;
  logic                     valid_q, valid_d;

  logic [LEN_W-1:0] length_in;
  logic [AW-1:0]    len_last;
  logic [31:0]      div_last;
  logic             running;

  logic                     we;
  logic [DATA_W-1:0]        wdata, rdata;
  logic signed [DATA_W-1:0] y, fb;
  logic signed [DATA_W:0]   sum, avg;
  logic signed [PW-1:0]     prod;

  // Length is stored as L-1 so DEPTH itself fits in the address width.
  assign length_in = bus.length;
  always_comb begin
    if (32'(length_in) < 32'd2) begin
      len_last = AW'(1);
    end else if (32'(length_in) > 32'(DEPTH)) begin
      len_last = AW'(DEPTH - 1);
    end else begin
      len_last = AW'(32'(length_in) - 32'd1);
    end
  end

  assign div_last = (bus.div_in < DIV_MIN) ? DIV_MIN - 32'd1 : bus.div_in - 32'd1;
  assign running  = (state_q == ST_RUN_WAIT) || (state_q == ST_RUN_RD) ||
                    (state_q == ST_RUN_WR);

  ks_delay_ram #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (we),
    .waddr_i (wp_q),
    .wdata_i (wdata),
    .raddr_i (wp_q),
    .rdata_o (rdata)
  );

  // Average at DATA_W+1 bits cannot overflow; the gain is < 1 so the shifted
  // product always fits back into DATA_W bits.
  assign y    = $signed(rdata);
  assign sum  = {y[DATA_W-1], y} + {z_q[DATA_W-1], z_q};
  assign avg  = sum >>> 1;
  assign prod = PW'(avg) * PW'($signed({1'b0, bus.decay}));
  assign fb   = DATA_W'(prod >>> DECAY_W);

  // NOTE: every variable gets a default before the branches, so no path can
  // leave one unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    wp_d    = wp_q;
    last_d  = last_q;
    cnt_d   = cnt_q;
    lfsr_d  = lfsr_q;
    z_d     = z_q;
    out_d   = out_q;
    valid_d = 1'b0;
    we      = 1'b0;
    wdata   = (state_q == ST_RUN_WR) ? fb : lfsr_q[31 -: DATA_W];

    if (bus.mute) begin
      state_d = ST_IDLE;
      out_d   = '0;
    end else if (bus.pluck && (state_q == ST_IDLE || running)) begin
      // A pluck while running abandons any pending write; output holds.
      state_d = ST_LOAD;
      last_d  = len_last;
      wp_d    = '0;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: out_d = '0;
        ST_LOAD: begin
          we     = 1'b1;
          lfsr_d = lfsr_step(lfsr_q);
          if (wp_q == last_q) begin
            wp_d    = '0;
            z_d     = '0;
            cnt_d   = '0;
            state_d = ST_RUN_WAIT;
          end else begin
            wp_d = wp_q + AW'(1);
          end
        end
        ST_RUN_WAIT: begin
          // >= rather than == so a shorter div_in written mid-note cannot
          // strand the counter above the new terminal count.
          if (cnt_q >= div_last) begin
            cnt_d   = '0;
            state_d = ST_RUN_RD;
          end else begin
            cnt_d = cnt_q + 32'd1;
          end
        end
        ST_RUN_RD: begin
          cnt_d   = cnt_q + 32'd1;
          state_d = ST_RUN_WR;
        end
        ST_RUN_WR: begin
          cnt_d   = cnt_q + 32'd1;
          we      = 1'b1;
          z_d     = y;
          out_d   = fb;
          valid_d = 1'b1;
          wp_d    = (wp_q == last_q) ? '0 : wp_q + AW'(1);
          state_d = ST_RUN_WAIT;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= ST_IDLE;
      wp_q    <= '0;
      last_q  <= '0;
      cnt_q   <= '0;
      lfsr_q  <= SEED;
      z_q     <= '0;
      out_q   <= '0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      wp_q    <= wp_d;
      last_q  <= last_d;
      cnt_q   <= cnt_d;
      lfsr_q  <= lfsr_d;
      z_q     <= z_d;
      out_q   <= out_d;
      valid_q <= valid_d;
    end
  end

  assign bus.sample_out   = out_q;
  assign bus.sample_valid = valid_q;
  assign bus.busy         = (state_q != ST_IDLE);

endmodule

// File: tb/tb_karplus_strong_voice.sv
// -----------------------------------------------------------------------------
// tb_karplus_strong_voice
// Self-checking bench. A string model (noise generator + FIFO delay line)
// predicts busy / sample_valid / sample_out each cycle; directed scenarios pin
// literal values and timings, then randomized plucks, mutes and length
// changes run against the model.
// -----------------------------------------------------------------------------
module tb_karplus_strong_voice;
  import karplus_pkg::*;

  localparam int          DATA_W  = 16;
  localparam int          DEPTH   = 1024;
  localparam int          LEN_W   = 11;
  localparam int          DECAY_W = 8;
  localparam logic [31:0] SEED    = 32'hACE1_0001;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  karplus_strong_voice_if #(.DATA_W(DATA_W), .LEN_W(LEN_W), .DECAY_W(DECAY_W)) bus ();

  karplus_strong_voice #(
    .DATA_W (DATA_W),
    .DEPTH  (DEPTH),
    .LEN_W  (LEN_W),
    .DECAY_W(DECAY_W),
    .SEED   (SEED)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic signed [63:0] actual,
                       input logic signed [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, actual, expected, $time);
    end
  endtask

  // ---------------- string model ----------------
  typedef enum {M_IDLE, M_LOAD, M_RUN} mode_t;

  mode_t       m_mode = M_IDLE;
  logic [31:0] m_lfsr = SEED;
  int          m_len, m_k, m_z;
  int          line[$];
  int          exp_out = 0;
  bit          exp_valid = 1'b0;

  function automatic logic [31:0] model_lfsr_next(input logic [31:0] s);
    logic [31:0] n;
    n = {1'b0, s[31:1]};
    if (s[0]) n = n ^ 32'h8020_0003;
    return n;
  endfunction

  function automatic int clamp_len(input int len);
    if (len < 2) return 2;
    if (len > DEPTH) return DEPTH;
    return len;
  endfunction

  function automatic int eff_div(input logic [31:0] d);
    return (d < 3) ? 3 : int'(d);
  endfunction

  task automatic model_step();
    int y, avg, fb, d;
    if (rst) begin
      m_mode = M_IDLE; m_lfsr = SEED; exp_out = 0; exp_valid = 1'b0; line.delete();
      return;
    end
    exp_valid = 1'b0;
    if (bus.mute) begin
      m_mode = M_IDLE; exp_out = 0;
    end else if (bus.pluck && m_mode != M_LOAD) begin
      m_len = clamp_len(int'(bus.length)); line.delete(); m_mode = M_LOAD;
    end else begin
      case (m_mode)
        M_LOAD: begin
          line.push_back(int'($signed(m_lfsr[31:16])));
          m_lfsr = model_lfsr_next(m_lfsr);
          if (line.size() == m_len) begin m_mode = M_RUN; m_k = 0; m_z = 0; end
        end
        M_RUN: begin
          m_k++;
          d = eff_div(bus.div_in);
          // Tick every d cycles from run entry, sample lands 2 cycles later.
          if (m_k >= d + 2 && (m_k - 2) % d == 0) begin
            y   = line.pop_front();
            avg = (y + m_z) >>> 1;
            fb  = (avg * int'(bus.decay)) >>> DECAY_W;
            line.push_back(fb);
            m_z = y; exp_out = fb; exp_valid = 1'b1;
          end
        end
        default: ;
      endcase
    end
  endtask

  // One compare process: model advances on the edge, DUT checked mid-cycle.
  initial begin
    forever begin
      @(posedge clk);
      model_step();
      @(negedge clk);
      if (!rst) begin
        check("busy", bus.busy, m_mode != M_IDLE);
        check("sample_valid", bus.sample_valid, exp_valid);
        check("sample_out", $signed(bus.sample_out), exp_out);
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic do_pluck(input int len, input int div, input int dec);
    bus.length = LEN_W'(len);
    bus.div_in = 32'(div);
    bus.decay  = DECAY_W'(dec);
    bus.pluck  = 1'b1;
    @(negedge clk);
    bus.pluck  = 1'b0;
  endtask

  // Negedges until sample_valid is seen; -1 if the budget expires.
  task automatic wait_valid(input int budget, output int n);
    n = 0;
    forever begin
      @(negedge clk);
      n++;
      if (bus.sample_valid === 1'b1) return;
      if (n >= budget) begin n = -1; return; end
    end
  endtask

  logic [15:0] seed_noise [4] = '{16'hACE1, 16'hD650, 16'hEB08, 16'h7584};

  task automatic check_seed_mem(input string tag);
    for (int i = 0; i < 4; i++)
      check($sformatf("%s_mem%0d", tag, i), dut.u_ram.mem[i], seed_noise[i]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation exceeded time limit, got running, expected finished");
    $fatal(1, "watchdog");
  end

  initial begin
    int n, len, n_cyc, r;
    logic [31:0] s;

    bus.pluck = 1'b0; bus.mute = 1'b0; bus.length = '0; bus.div_in = 32'd10; bus.decay = '0;
    rst = 1'b1;
    tick(3);
    rst = 1'b0;
    tick(1);
    check("reset_busy", bus.busy, 0);
    check("reset_valid", bus.sample_valid, 0);
    check("reset_sample", $signed(bus.sample_out), 0);

    // Pin the model noise generator against hand-derived words.
    s = SEED;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("model_noise%0d", i), s[31:16], seed_noise[i]);
      s = model_lfsr_next(s);
    end

    // L=4, div=10, decay=255: load, timing and first three samples.
    do_pluck(4, 10, 255);
    check("busy_after_pluck", bus.busy, 1);
    tick(4);
    check_seed_mem("load");
    wait_valid(100, n); check("first_valid_after_run_entry", n, 12);
    check("sample0", $signed(bus.sample_out), -10599);
    wait_valid(100, n); check("period10_a", n, 10);
    check("sample1", $signed(bus.sample_out), -15914);
    wait_valid(100, n); check("period10_b", n, 10);
    check("sample2", $signed(bus.sample_out), -7989);

    // Re-pluck while running with L=8.
    do_pluck(8, 10, 255);
    wait_valid(200, n); check("repluck_first_valid", n, 20);

    // Mute during RUN_RD.
    tick(8);
    check("in_run_rd", dut.state_q, ST_RUN_RD);
    bus.mute = 1'b1;
    tick(1);
    bus.mute = 1'b0;
    check("mute_busy", bus.busy, 0);
    check("mute_sample", $signed(bus.sample_out), 0);
    check("mute_valid", bus.sample_valid, 0);
    tick(15);

    // length=0 clamps to 2, div_in=1 acts as 3.
    do_pluck(0, 1, 200);
    wait_valid(100, n); check("len0_first_valid", n, 7);
    for (int i = 0; i < 6; i++) begin
      wait_valid(20, n); check("div1_period", n, 3);
    end

    // decay=0 silences the string.
    do_pluck(4, 5, 0);
    wait_valid(100, n); check("decay0_first_valid", n, 11);
    for (int i = 0; i < 11; i++) begin
      wait_valid(20, n); check("decay0_period", n, 5);
      check("decay0_sample", $signed(bus.sample_out), 0);
    end

    // length=2000 clamps to DEPTH; run past two full wraps.
    do_pluck(2000, 3, 250);
    wait_valid(2000, n); check("len_max_first_valid", n, 1029);
    for (int i = 0; i < 2 * DEPTH + 2; i++) begin
      wait_valid(10, n); check("len_max_period", n, 3);
    end

    // Asynchronous reset between edges during LOAD.
    do_pluck(16, 4, 255);
    tick(5);
    #2 rst = 1'b1;
    #1;
    check("async_rst_busy", bus.busy, 0);
    check("async_rst_valid", bus.sample_valid, 0);
    check("async_rst_sample", $signed(bus.sample_out), 0);
    @(negedge clk);
    rst = 1'b0;
    do_pluck(4, 4, 255);
    tick(4);
    check_seed_mem("reseed");
    wait_valid(100, n); check("reseed_first_valid", n, 6);
    check("reseed_sample0", $signed(bus.sample_out), -10599);

    // Randomized plucks, mutes and stray length changes.
    for (int it = 0; it < 30; it++) begin
      len = $urandom_range(0, 20);
      do_pluck(len, $urandom_range(0, 12), $urandom_range(0, 255));
      n_cyc = $urandom_range(20, 300);
      for (int c = 0; c < n_cyc; c++) begin
        @(negedge clk);
        r = $urandom_range(0, 99);
        bus.mute = (r < 2);
        if (r >= 2 && r < 6) bus.length = LEN_W'($urandom_range(0, 40));
      end
      bus.mute = 1'b0;
    end
    tick(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/karplus_strong_voice.md
Name: karplus_strong_voice

Overview:
- Parametrised next-generation Karplus-Strong plucked-string voice. The delay line is a circular-buffer memory of DEPTH words, replacing a fixed shift register.
- Adds the following over the previous generation:
  - runtime string length;
  - internal LFSR excitation with an automatic noise-load FSM;
  - programmable decay gain;
  - a signed sample path;
  - a valid strobe on each output sample.
- Sits between the Nios-side control registers (pluck, length, pitch divider, decay) and the audio DAC/codec sample path.

Parameters:
- DATA_W, 16, sample width. Signed two's complement. Range 8..32.
- DEPTH, 1024, maximum delay-line length in words.
- LEN_W, 10, length port width. Must satisfy 2^LEN_W >= DEPTH.
- DECAY_W, 8, decay gain width. Gain = decay / 2^DECAY_W.
- SEED, 32'hACE1_0001, LFSR reset value. Must be non-zero.

Ports:
- clk, in, 1, system clock.
- rst, in, 1, asynchronous reset, active-high.
- pluck, in, 1, one-cycle pulse that starts the excitation.
- mute, in, 1, level input. Forces the voice to IDLE.
- length, in, LEN_W, delay-line length L. Latched on pluck.
- div_in, in, 32, sample period in clk cycles.
- decay, in, DECAY_W, feedback gain. Sampled at every tick.
- sample_out, out, DATA_W, signed synthesized sample.
- sample_valid, out, 1, one-cycle strobe when sample_out updates.
- busy, out, 1, high in LOAD or RUN.

Behaviour:
- Reset values:
  - state = IDLE; sample_out = 0; sample_valid = 0; busy = 0.
  - z = 0; wp = 0; divider count = 0; LFSR = SEED.
  - Memory contents are undefined.
- Length clamp at latch: L < 2 becomes 2; L > DEPTH becomes DEPTH.
- div_in clamp: any value < 3 is treated as 3, the pipeline minimum.
- LFSR: 32-bit Galois, taps 0x80200003, shifts right. Noise word = LFSR[31:32-DATA_W]. Advances once per LOAD write only.
- State IDLE:
  - busy = 0; sample_out held at 0.
  - pluck latches L and goes to LOAD with wp = 0 and count = 0.
- State LOAD:
  - One write per clk: mem[wp] = noise; LFSR advances; wp increments.
  - After exactly L writes: wp = 0, z = 0, divider count = 0, go to RUN_WAIT. No sample_valid is issued during LOAD.
- State RUN_WAIT:
  - Divider count increments each clk.
  - When count == div_in-1: count = 0, tick, go to RUN_RD.
  - The tick period is exactly div_in clk cycles.
- State RUN_RD (1 cycle):
  - y = mem[wp] (synchronous read). This is the oldest sample, L ticks old.
- State RUN_WR (1 cycle):
  - avg = (y + z) >>> 1, computed at DATA_W+1 bits, so no overflow.
  - fb = (avg * decay) >>> DECAY_W, signed multiply, truncated toward negative infinity.
  - mem[wp] = fb; z = y; sample_out = fb; sample_valid = 1.
  - wp = (wp == L-1) ? 0 : wp+1.
  - Return to RUN_WAIT. The divider keeps counting through RUN_RD and RUN_WR.
- Latency: sample_valid is asserted 2 clk after the tick cycle.
- pluck during LOAD is ignored.
- pluck during RUN_* restarts LOAD with a newly latched L. sample_out holds its last value until the next valid.
- length changes outside a pluck are ignored.
- mute has priority over pluck. Any state goes to IDLE next cycle with sample_out = 0 and sample_valid = 0. The LFSR is not reseeded.
- Reset asserted mid-operation: all registers clear immediately. The pointer, z and FSM return to reset values.
- decay = 0: every output is 0 after the first pass.
- decay = 2^DECAY_W - 1: slowest decay, always strictly below unity.

Decomposition:
- Shared package karplus_pkg holds:
  - state encoding (IDLE, LOAD, RUN_WAIT, RUN_RD, RUN_WR);
  - the LFSR tap constant 0x80200003;
  - the minimum div value 3.
- One sub-module: ks_delay_ram. Simple dual-port DEPTH x DATA_W memory with synchronous read, inferable as block RAM.
- The LFSR, divider and FSM stay in the top level.

Test Plan:
- Reset then pluck with length=4, div_in=10, decay=255, DATA_W=16 -> busy goes high; exactly 4 LOAD writes occur; mem[0..3] matches a reference LFSR from SEED; the first sample_valid appears 12 clk after RUN_WAIT entry, then every 10 clk.
- Same setup, 3 consecutive samples -> sample_out equals the golden model ((y+z)>>>1)*255>>>8, with z=0 for the first sample and the first fb = (mem[0]>>>1)*255>>>8. Check exact signed values against a C model.
- length=0 and length=2000 -> the LOAD phase lasts 2 and 1024 cycles respectively. wp wraps at 1 and 1023.
- div_in=1 -> the effective sample_valid period is 3 clk.
- decay=0 -> after 2*L samples, sample_out = 0 for all subsequent samples.
- pluck during RUN with new length=8 -> LOAD restarts with 8 writes. Separately, assert mute in RUN_RD -> next cycle state is IDLE, sample_out = 0, no valid.
- Async rst asserted mid-LOAD, between clock edges -> outputs clear before the next edge. A subsequent pluck reproduces the SEED noise sequence.
